// File: rtl/operand_fetch.sv
// Operand fetch stage: drives the regfile read ports, resolves sources with writeback
// bypass, tracks in-flight destinations in a busy scoreboard and stalls on RAW/WAW.
module operand_fetch #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_rs1,
    input  logic [ADDR_WIDTH-1:0] in_rs2,
    input  logic                  in_use1,
    input  logic                  in_use2,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_wb,
    output logic                  rf_rd_en1,
    output logic                  rf_rd_en2,
    output logic [ADDR_WIDTH-1:0] rf_rd_addr1,
    output logic [ADDR_WIDTH-1:0] rf_rd_addr2,
    input  logic [DATA_WIDTH-1:0] rf_rd_data1,
    input  logic [DATA_WIDTH-1:0] rf_rd_data2,
    input  logic                  wb_en,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_op1,
    output logic [DATA_WIDTH-1:0] out_op2,
    output logic [ADDR_WIDTH-1:0] out_rd,
    output logic                  out_wb,
    output logic                  idle
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   busy_next;
    logic [DATA_WIDTH-1:0] op1;
    logic [DATA_WIDTH-1:0] op2;
    logic                  wb_hit1;
    logic                  wb_hit2;
    logic                  wb_hit_rd;
    logic                  raw1;
    logic                  raw2;
    logic                  waw;
    logic                  hazard;
    logic                  accept;

    assign rf_rd_addr1 = in_rs1;
    assign rf_rd_addr2 = in_rs2;
    assign rf_rd_en1   = in_valid && in_use1;
    assign rf_rd_en2   = in_valid && in_use2;

    assign wb_hit1   = wb_en && (wb_addr == in_rs1);
    assign wb_hit2   = wb_en && (wb_addr == in_rs2);
    assign wb_hit_rd = wb_en && (wb_addr == in_rd);

    // A writeback landing this cycle both supplies the data and retires the hazard.
    assign raw1   = in_use1 && (in_rs1 != '0) && busy[in_rs1] && !wb_hit1;
    assign raw2   = in_use2 && (in_rs2 != '0) && busy[in_rs2] && !wb_hit2;
    assign waw    = in_wb && (in_rd != '0) && busy[in_rd] && !wb_hit_rd;
    assign hazard = raw1 || raw2 || waw;

    assign in_ready = (!out_valid || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    always_comb begin
        op1 = rf_rd_data1;
        if (!in_use1 || (in_rs1 == '0)) begin
            op1 = '0;
        end else if (wb_hit1) begin
            op1 = wb_data;
        end
    end

    always_comb begin
        op2 = rf_rd_data2;
        if (!in_use2 || (in_rs2 == '0)) begin
            op2 = '0;
        end else if (wb_hit2) begin
            op2 = wb_data;
        end
    end

    // Clear before set so a same-cycle set of the same register wins.
    always_comb begin
        busy_next = busy;
        if (wb_en && (wb_addr != '0)) begin
            busy_next[wb_addr] = 1'b0;
        end
        if (accept && in_wb && (in_rd != '0)) begin
            busy_next[in_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= '0;
            out_valid <= 1'b0;
            out_op1   <= '0;
            out_op2   <= '0;
            out_rd    <= '0;
            out_wb    <= 1'b0;
        end else begin
            busy <= busy_next;
            if (accept) begin
                out_valid <= 1'b1;
                out_op1   <= op1;
                out_op2   <= op2;
                out_rd    <= in_rd;
                out_wb    <= in_wb;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign idle = (busy == '0) && !out_valid;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed vector table plus randomized
// traffic checked against a scoreboard-level reference model.
module tb_operand_fetch;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic        in_use1;
    logic        in_use2;
    logic [4:0]  in_rd;
    logic        in_wb;
    logic        rf_rd_en1;
    logic        rf_rd_en2;
    logic [4:0]  rf_rd_addr1;
    logic [4:0]  rf_rd_addr2;
    logic [31:0] rf_rd_data1;
    logic [31:0] rf_rd_data2;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_op1;
    logic [31:0] out_op2;
    logic [4:0]  out_rd;
    logic        out_wb;
    logic        idle;

    logic [31:0] mem [32];
    int          checks;
    int          errors;

    assign rf_rd_data1 = mem[rf_rd_addr1];
    assign rf_rd_data2 = mem[rf_rd_addr2];

    operand_fetch #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use1(in_use1), .in_use2(in_use2),
        .in_rd(in_rd), .in_wb(in_wb),
        .rf_rd_en1(rf_rd_en1), .rf_rd_en2(rf_rd_en2),
        .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
        .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd), .out_wb(out_wb),
        .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic [4:0]  rd;
        logic        wb;
        logic        wben;
        logic [4:0]  wbaddr;
        logic [31:0] wbdata;
        logic        ordy;
        logic        e_rdy;
        logic        e_ov;
        logic [31:0] e_op1;
        logic [31:0] e_op2;
        logic [4:0]  e_rd;
        logic        e_wb;
        logic        e_idle;
    } vec_t;

    localparam int NVEC = 17;
    vec_t tbl [NVEC];

    // reference model state
    bit          m_busy [32];
    bit          m_ov;
    logic [31:0] m_op1;
    logic [31:0] m_op2;
    logic [4:0]  m_rd;
    bit          m_wb;

    function automatic vec_t mk(logic r, logic iv, logic [4:0] rs1, logic [4:0] rs2,
                                logic u1, logic u2, logic [4:0] rd, logic wb,
                                logic wben, logic [4:0] wbaddr, logic [31:0] wbdata,
                                logic ordy, logic e_rdy, logic e_ov, logic [31:0] e_op1,
                                logic [31:0] e_op2, logic [4:0] e_rd, logic e_wb,
                                logic e_idle);
        vec_t v;
        v.rst = r; v.iv = iv; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
        v.rd = rd; v.wb = wb; v.wben = wben; v.wbaddr = wbaddr; v.wbdata = wbdata;
        v.ordy = ordy; v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_op1 = e_op1;
        v.e_op2 = e_op2; v.e_rd = e_rd; v.e_wb = e_wb; v.e_idle = e_idle;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; in_valid = v.iv; in_rs1 = v.rs1; in_rs2 = v.rs2;
        in_use1 = v.u1; in_use2 = v.u2; in_rd = v.rd; in_wb = v.wb;
        wb_en = v.wben; wb_addr = v.wbaddr; wb_data = v.wbdata; out_ready = v.ordy;
    endtask

    // Regfile write port, applied just after the edge.
    task automatic edge_and_write();
        @(posedge clk);
        #1;
        if (wb_en && wb_addr != 5'd0) mem[wb_addr] = wb_data;
    endtask

    function automatic bit pending(input logic [4:0] r);
        return (r != 5'd0) && m_busy[r] && !(wb_en && wb_addr == r);
    endfunction

    function automatic logic [31:0] resolve(input logic use_it, input logic [4:0] rs);
        if (!use_it || rs == 5'd0) return 32'd0;
        if (wb_en && wb_addr == rs) return wb_data;
        return mem[rs];
    endfunction

    function automatic bit model_idle();
        for (int i = 0; i < 32; i++) if (m_busy[i]) return 1'b0;
        return !m_ov;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_ov = 1'b0; m_op1 = '0; m_op2 = '0; m_rd = '0; m_wb = 1'b0;
    endtask

    initial begin
        vec_t z;
        bit          exp_rdy;
        bit          acc;
        logic [31:0] nop1;
        logic [31:0] nop2;

        checks = 0;
        errors = 0;
        for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + i;
        mem[0] = 32'hFFFF_FFFF;
        mem[3] = 32'h11;
        mem[4] = 32'h22;

        tbl[0]  = mk(0,1,3,4,1,1,0,0, 0,0,32'h0,        1, 1,1,32'h11,32'h0,0,0,0);
        tbl[0].e_op2 = 32'h22;
        tbl[1]  = mk(0,1,0,0,0,0,5,1, 0,0,32'h0,        1, 1,1,32'h0,32'h0,5,1,0);
        tbl[2]  = mk(0,1,5,0,1,0,0,0, 0,0,32'h0,        1, 0,0,32'h0,32'h0,5,1,0);
        tbl[3]  = mk(0,1,5,0,1,0,0,0, 1,5,32'hDEADBEEF, 1, 1,1,32'hDEADBEEF,32'h0,0,0,0);
        tbl[4]  = mk(0,0,0,0,0,0,0,0, 0,0,32'h0,        1, 1,0,32'hDEADBEEF,32'h0,0,0,1);
        tbl[5]  = mk(0,1,0,0,1,1,0,1, 0,0,32'h0,        1, 1,1,32'h0,32'h0,0,1,0);
        tbl[6]  = mk(0,1,0,4,1,1,6,0, 0,0,32'h0,        1, 1,1,32'h0,32'h22,6,0,0);
        tbl[7]  = mk(0,1,3,4,1,1,7,1, 0,0,32'h0,        0, 0,1,32'h0,32'h22,6,0,0);
        tbl[8]  = tbl[7];
        tbl[9]  = tbl[7];
        tbl[10] = mk(0,1,3,4,1,1,7,1, 1,7,32'h77,       1, 1,1,32'h11,32'h22,7,1,0);
        tbl[11] = mk(0,1,7,0,1,0,0,0, 0,0,32'h0,        1, 0,0,32'h11,32'h22,7,1,0);
        tbl[12] = mk(0,0,0,0,0,0,0,0, 1,7,32'h78,       1, 1,0,32'h11,32'h22,7,1,1);
        tbl[13] = mk(0,1,0,0,0,0,9,1, 0,0,32'h0,        1, 1,1,32'h0,32'h0,9,1,0);
        tbl[14] = mk(1,0,0,0,0,0,0,0, 0,0,32'h0,        1, 1,0,32'h0,32'h0,0,0,1);
        tbl[15] = mk(0,1,9,0,1,0,0,0, 0,0,32'h0,        1, 1,1,32'h10000009,32'h0,0,0,0);
        tbl[16] = mk(0,0,0,0,0,0,0,0, 1,9,32'h99,       1, 1,0,32'h10000009,32'h0,0,0,1);

        z = mk(1,0,0,0,0,0,0,0, 0,0,32'h0, 0, 0,0,32'h0,32'h0,0,0,0);
        @(negedge clk);
        drive(z);
        edge_and_write();
        edge_and_write();
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_op1", out_op1, 32'd0);
        chk("reset_out_op2", out_op2, 32'd0);
        chk("reset_out_rd", {27'd0, out_rd}, 32'd0);
        chk("reset_out_wb", {31'd0, out_wb}, 32'd0);
        chk("reset_idle", {31'd0, idle}, 32'd1);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].e_rdy});
            edge_and_write();
            chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].e_ov});
            chk($sformatf("vec%0d_out_op1", i), out_op1, tbl[i].e_op1);
            chk($sformatf("vec%0d_out_op2", i), out_op2, tbl[i].e_op2);
            chk($sformatf("vec%0d_out_rd", i), {27'd0, out_rd}, {27'd0, tbl[i].e_rd});
            chk($sformatf("vec%0d_out_wb", i), {31'd0, out_wb}, {31'd0, tbl[i].e_wb});
            chk($sformatf("vec%0d_idle", i), {31'd0, idle}, {31'd0, tbl[i].e_idle});
        end

        // Hand sequence: r0 writeback is ignored and never leaves a busy bit.
        @(negedge clk);
        drive(z);
        rst = 1'b0; out_ready = 1'b1; wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h5;
        edge_and_write();
        chk("wb_r0_idle", {31'd0, idle}, 32'd1);
        chk("wb_r0_mem_untouched", mem[0], 32'hFFFF_FFFF);

        // Randomized traffic against the reference model.
        @(negedge clk);
        drive(z);
        edge_and_write();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 99) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            in_rs1    = 5'($urandom_range(0, 7));
            in_rs2    = 5'($urandom_range(0, 7));
            in_use1   = 1'($urandom);
            in_use2   = 1'($urandom);
            in_rd     = 5'($urandom_range(0, 7));
            in_wb     = 1'($urandom);
            wb_en     = ($urandom_range(0, 9) < 4);
            wb_addr   = 5'($urandom_range(0, 7));
            wb_data   = $urandom;
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            exp_rdy = (!m_ov || out_ready) &&
                      !((in_use1 && pending(in_rs1)) || (in_use2 && pending(in_rs2)) ||
                        (in_wb && pending(in_rd)));
            chk("rand_in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
            chk("rand_rf_en", {30'd0, rf_rd_en2, rf_rd_en1},
                {30'd0, in_valid && in_use2, in_valid && in_use1});
            chk("rand_rf_addr", {22'd0, rf_rd_addr2, rf_rd_addr1}, {22'd0, in_rs2, in_rs1});
            acc  = in_valid && exp_rdy;
            nop1 = resolve(in_use1, in_rs1);
            nop2 = resolve(in_use2, in_rs2);
            if (rst) begin
                model_reset();
            end else begin
                if (wb_en && wb_addr != 5'd0) m_busy[wb_addr] = 1'b0;
                if (acc && in_wb && in_rd != 5'd0) m_busy[in_rd] = 1'b1;
                if (acc) begin
                    m_ov = 1'b1; m_op1 = nop1; m_op2 = nop2; m_rd = in_rd; m_wb = in_wb;
                end else if (out_ready) begin
                    m_ov = 1'b0;
                end
            end
            edge_and_write();
            chk("rand_out_valid", {31'd0, out_valid}, {31'd0, m_ov});
            chk("rand_out_op1", out_op1, m_op1);
            chk("rand_out_op2", out_op2, m_op2);
            chk("rand_out_rd_wb", {26'd0, out_wb, out_rd}, {26'd0, m_wb, m_rd});
            chk("rand_idle", {31'd0, idle}, {31'd0, model_idle()});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
